// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
// Shared constants for the instruction-fetch stage.
//   NOP_INSTR : canonical bubble word (addi x0, x0, 0). It is also the
//               reset value of the IF/ID instruction register.
//   ENTRY_W   : width of one prefetch queue entry, {pc, instr}.
//   pcPlus4   : sequential-PC helper; wraps modulo 2^32 with no flag.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          ENTRY_W   = 64;

    function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
// Synchronous FIFO that buffers fetched {pc, instr} words while decode is
// stalled or while it is still draining older entries.
// Ports:
//   clk, resetn       : clock, asynchronous active-low reset
//   push, pushData    : write one entry at the tail
//   pop               : discard the head entry (only issued when non-empty)
//   clear             : drop every entry; wins over push and pop
//   headData          : current head entry (meaningful when empty = 0)
//   count             : number of entries held, 0..DEPTH
//   empty             : count == 0
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         headData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (clear) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_ONE;
            if (pop)  rdPtr <= rdPtr + PTR_ONE;
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;
        end
    end

    // Storage needs no reset: the pointers define which slots are live.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= pushData;
    end

    assign headData = mem[rdPtr];
    assign empty    = (count == '0);

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage: owns the fetch PC (PCF), issues instruction
// memory requests, buffers returned words in a small prefetch queue and
// drives the IF/ID register consumed by decode.
//
// Handshake: a request is valid when imem_valid = 1 with its address on
// imem_addr; the memory accepts it in any cycle where imem_ready = 1 and
// returns imem_rdata in that same cycle. A transfer happens exactly when
// imem_valid & imem_ready. imem_valid depends only on reset and queue
// occupancy, and imem_addr may change (redirect) before a transfer, so the
// memory samples the address only on the transfer itself.
//
// Ports:
//   clk, resetn            : clock, asynchronous active-low reset
//   imem_valid, imem_addr  : fetch request and its word-aligned address
//   imem_ready, imem_rdata : memory accept and returned instruction word
//   PCSrcE, PCTargetE      : redirect from execute (target bits [1:0] ignored)
//   StallD, FlushD         : hold / bubble the IF/ID register
//   InstrD, PCD, PCPlus4D  : IF/ID instruction, its PC and PC+4
//   ValidD                 : 1 = real instruction, 0 = bubble
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR  = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    input  logic        FlushD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);

    logic [31:0]      pcF;
    logic [CNT_W-1:0] queueCount;
    logic             queueEmpty;
    logic [63:0]      queueHead;
    logic             accept;
    logic             decodeLoad;
    logic             queuePop;
    logic             bypass;
    logic             queuePush;

    assign imem_valid = resetn && (queueCount != FULL_COUNT);
    assign imem_addr  = pcF;
    assign accept     = imem_valid && imem_ready;

    // IF/ID takes a new entry only when nothing above it holds or kills it.
    assign decodeLoad = !StallD && !FlushD && !PCSrcE;
    // Older queued words always go first so program order is preserved;
    // the fresh word bypasses the queue only when the queue is empty.
    assign queuePop   = decodeLoad && !queueEmpty;
    assign bypass     = decodeLoad && queueEmpty && accept;
    // A word accepted during a redirect belongs to the wrong path: drop it.
    assign queuePush  = accept && !PCSrcE && !bypass;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk      (clk),
        .resetn   (resetn),
        .push     (queuePush),
        .pushData ({pcF, imem_rdata}),
        .pop      (queuePop),
        .clear    (PCSrcE),
        .headData (queueHead),
        .count    (queueCount),
        .empty    (queueEmpty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcF <= RESET_ADDR;
        end else if (PCSrcE) begin
            pcF <= {PCTargetE[31:2], 2'b00};
        end else if (accept) begin
            pcF <= pcPlus4(pcF);
        end
    end

    // Bubbles replace only the instruction and valid bit; PCD/PCPlus4D keep
    // their last values so they never carry a meaningless address.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'h0000_0000;
            PCPlus4D <= 32'h0000_0000;
            ValidD   <= 1'b0;
        end else if (PCSrcE || FlushD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (!StallD) begin
            if (queuePop) begin
                InstrD   <= queueHead[31:0];
                PCD      <= queueHead[63:32];
                PCPlus4D <= pcPlus4(queueHead[63:32]);
                ValidD   <= 1'b1;
            end else if (bypass) begin
                InstrD   <= imem_rdata;
                PCD      <= pcF;
                PCPlus4D <= pcPlus4(pcF);
                ValidD   <= 1'b1;
            end else begin
                InstrD <= NOP_INSTR;
                ValidD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] RESET_ADDR  = 32'h0000_0000;
    localparam int          QUEUE_DEPTH = 2;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic        FlushD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    fetch_stage #(
        .RESET_ADDR  (RESET_ADDR),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .imem_valid (imem_valid),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    // Instruction memory: the word at an address is derived from the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[27:0], 4'h7};
    endfunction

    assign imem_rdata = memWord(imem_addr);

    // ---------------- checking ----------------
    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: expected PC stream, refilled whenever the bench starts a
    // new fetch path (reset release or redirect).
    logic [31:0] expQ[$];

    typedef enum logic [1:0] {K_LOAD, K_HOLD, K_BUBBLE} kind_t;
    kind_t       prevKind;
    logic [31:0] heldPc;
    logic [31:0] heldP4;
    logic [31:0] heldInstr;
    logic        heldValid;

    task automatic fillExp(input logic [31:0] start);
        expQ.delete();
        for (int i = 0; i < 24; i++) expQ.push_back(start + 32'(4 * i));
    endtask

    task automatic resetHeld();
        heldPc    = 32'h0;
        heldP4    = 32'h0;
        heldInstr = NOP;
        heldValid = 1'b0;
        prevKind  = K_BUBBLE;
    endtask

    task automatic bubbleCheck();
        chk("bubble_instr", InstrD, NOP);
        chk("bubble_pcd", PCD, heldPc);
        chk("bubble_pcplus4d", PCPlus4D, heldP4);
        heldInstr = NOP;
        heldValid = 1'b0;
    endtask

    task automatic sbCheck();
        logic [31:0] pc;
        case (prevKind)
            K_LOAD: begin
                if (ValidD) begin
                    if (expQ.size() == 0) begin
                        total++;
                        $display("FAIL sb_underflow: got valid PCD %h, expected no instruction", PCD);
                    end else begin
                        pc = expQ.pop_front();
                        chk("sb_pcd", PCD, pc);
                        chk("sb_instrd", InstrD, memWord(pc));
                        chk("sb_pcplus4d", PCPlus4D, pc + 32'd4);
                        heldPc    = pc;
                        heldP4    = pc + 32'd4;
                        heldInstr = memWord(pc);
                        heldValid = 1'b1;
                    end
                end else begin
                    bubbleCheck();
                end
            end
            K_BUBBLE: begin
                chk("bubble_validd", 32'(ValidD), 32'h0);
                bubbleCheck();
            end
            default: begin
                chk("hold_instr", InstrD, heldInstr);
                chk("hold_pcd", PCD, heldPc);
                chk("hold_pcplus4d", PCPlus4D, heldP4);
                chk("hold_validd", 32'(ValidD), 32'(heldValid));
            end
        endcase
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_instrd"}, InstrD, NOP);
        chk({tag, "_pcd"}, PCD, 32'h0);
        chk({tag, "_pcplus4d"}, PCPlus4D, 32'h0);
        chk({tag, "_validd"}, 32'(ValidD), 32'h0);
        chk({tag, "_imem_valid"}, 32'(imem_valid), 32'h0);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        rdy;
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] tgt;
        logic        expIv;
        logic        expVd;
        logic [31:0] expAddr;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic rdy, input logic stall, input logic flush,
                          input logic redir, input logic [31:0] tgt,
                          input logic expIv, input logic expVd, input logic [31:0] expAddr);
        vec_t v;
        v.rdy = rdy; v.stall = stall; v.flush = flush; v.redir = redir; v.tgt = tgt;
        v.expIv = expIv; v.expVd = expVd; v.expAddr = expAddr;
        vecs.push_back(v);
    endtask

    // Driver: inputs change 1 time unit after the rising edge, outputs are
    // sampled on the falling edge of the same cycle.
    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        resetn     = 1'b1;
        imem_ready = v.rdy;
        StallD     = v.stall;
        FlushD     = v.flush;
        PCSrcE     = v.redir;
        PCTargetE  = v.tgt;
        @(negedge clk);
        chk("imem_valid", 32'(imem_valid), 32'(v.expIv));
        chk("imem_addr", imem_addr, v.expAddr);
        chk("validd", 32'(ValidD), 32'(v.expVd));
        sbCheck();
        if (v.redir || v.flush) prevKind = K_BUBBLE;
        else if (v.stall)       prevKind = K_HOLD;
        else                    prevKind = K_LOAD;
        if (v.redir) fillExp({v.tgt[31:2], 2'b00});
    endtask

    initial begin
        resetn     = 1'b0;
        imem_ready = 1'b0;
        StallD     = 1'b0;
        FlushD     = 1'b0;
        PCSrcE     = 1'b0;
        PCTargetE  = 32'h0;
        resetHeld();

        //      rdy  stl  fls  red  target          iv   vd   imem_addr
        // Streaming from reset.
        addVec(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0000_0000);
        addVec(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_0004);
        addVec(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_0008);
        // Memory not ready for three cycles.
        addVec(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_000C);
        addVec(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0000_000C);
        addVec(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0000_000C);
        addVec(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0000_000C);
        // Four-cycle stall: two accepts fill the queue, then imem_valid drops.
        addVec(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_0010);
        addVec(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_0014);
        addVec(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0000_0018);
        addVec(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0000_0018);
        // Release: queue drains in order while fetching resumes.
        addVec(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0000_0018);
        addVec(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_0018);
        addVec(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_001C);
        // One-cycle flush.
        addVec(1'b1,1'b0,1'b1,1'b0,32'h0,        1'b1,1'b1,32'h0000_0020);
        addVec(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0000_0024);
        addVec(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_0024);
        // Fill the queue under stall, then redirect with a misaligned target.
        addVec(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_0028);
        addVec(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0000_002C);
        addVec(1'b1,1'b1,1'b0,1'b1,32'h0000_0103,1'b0,1'b1,32'h0000_002C);
        addVec(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0000_0100);
        addVec(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_0104);
        // Redirect while a word is being accepted; target near the top of memory.
        addVec(1'b1,1'b0,1'b0,1'b1,32'hFFFF_FFFB,1'b1,1'b1,32'h0000_0108);
        addVec(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'hFFFF_FFF8);
        addVec(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'hFFFF_FFFC);
        addVec(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_0000);
        // Leave words in the queue before the mid-stream reset.
        addVec(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_0004);
        addVec(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_0008);
        // After the mid-stream reset.
        addVec(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0000_0000);
        addVec(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_0004);
        addVec(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_0008);

        // Power-on reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkReset("por");

        fillExp(RESET_ADDR);
        resetHeld();
        for (int i = 0; i < 28; i++) step(vecs[i]);

        // Asynchronous reset mid-cycle with a non-empty queue.
        #2;
        resetn = 1'b0;
        #1;
        checkReset("async");
        StallD     = 1'b0;
        imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkReset("held");

        fillExp(RESET_ADDR);
        resetHeld();
        for (int i = 28; i < 31; i++) step(vecs[i]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
